// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and constants for the instruction fetch unit.
//   word_t        - 32-bit machine word (PC, addresses, instructions)
//   fetch_state_t - fetch FSM states
//   PcIncr        - sequential PC increment
package fetch_unit_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StHold
    } fetch_state_t;

    localparam word_t PcIncr = 32'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bundle.
//   imem_req_valid  fetch -> mem   request valid
//   imem_req_ready  mem -> fetch   request accepted
//   imem_addr       fetch -> mem   request address
//   imem_resp_valid mem -> fetch   response data valid
//   imem_resp_data  mem -> fetch   fetched instruction
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic  imem_req_valid;
    logic  imem_req_ready;
    word_t imem_addr;
    logic  imem_resp_valid;
    word_t imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );

endinterface

// File: rtl/pc_reg.sv
// pc_reg: program counter register with next-PC selection.
//   clk, reset_n   clock, synchronous active-low reset (loads RESET_PC)
//   pc_wren        update strobe
//   branch_taken   take branch_target instead of pc+4
//   branch_target  redirect address
//   pc             current PC (registered)
//   misaligned     combinational flag: this cycle's branch update was rejected
module pc_reg
    import fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  pc_wren,
    input  logic  branch_taken,
    input  word_t branch_target,
    output word_t pc,
    output logic  misaligned
);

    word_t pc_q, pc_d;

    always_comb begin
        misaligned = pc_wren && branch_taken && (branch_target[1:0] != 2'b00);
        pc_d       = pc_q;
        if (pc_wren) begin
            if (branch_taken) begin
                // A misaligned target leaves the PC where it was.
                if (!misaligned) begin
                    pc_d = branch_target;
                end
            end else begin
                pc_d = pc_q + PcIncr;  // wraps modulo 2^32
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage. Issues one instruction-memory request per fetch_start,
// buffers the response and hands it to the IF/ID register on if_id_wren.
//   clk, reset_n        clock, synchronous active-low reset
//   stage_reset_n       synchronous active-low abort of the fetch FSM (PC kept)
//   fetch_start         IF entry pulse; ignored unless idle
//   pc_wren, branch_taken, branch_target   PC update controls
//   if_id_wren          IF/ID load strobe, honoured only while holding a response
//   imem                instruction-memory bundle (master side)
//   pc                  current PC
//   if_id_pc/instr/valid  IF/ID pipeline register
//   fetch_busy          request or wait in progress (combinational from state)
//   fetch_err           sticky: misaligned branch target or response timeout
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter word_t       RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                stage_reset_n,
    input  logic                fetch_start,
    input  logic                pc_wren,
    input  logic                if_id_wren,
    input  logic                branch_taken,
    input  word_t               branch_target,
    fetch_unit_if.master        imem,
    output word_t               pc,
    output word_t               if_id_pc,
    output word_t               if_id_instr,
    output logic                if_id_valid,
    output logic                fetch_busy,
    output logic                fetch_err
);

    localparam int unsigned    CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    fetch_state_t    state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    word_t           addr_q, addr_d;
    word_t           buf_q, buf_d;
    word_t           if_pc_q, if_pc_d;
    word_t           if_instr_q, if_instr_d;
    logic            if_valid_q, if_valid_d;
    logic            req_valid_q, req_valid_d;
    logic            err_q, err_d;
    logic            timeout;
    logic            misaligned;
    word_t           pc_cur;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .reset_n       (reset_n),
        .pc_wren       (pc_wren),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc_cur),
        .misaligned    (misaligned)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        buf_d      = buf_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;
        timeout    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fetch_start) begin
                    state_d = StReq;
                    addr_d  = pc_cur;
                end
            end
            StReq: begin
                if (imem.imem_req_ready) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end
            end
            StWait: begin
                if (imem.imem_resp_valid) begin
                    buf_d   = imem.imem_resp_data;
                    state_d = StHold;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    // TIMEOUT wait cycles have now elapsed with no response.
                    timeout = 1'b1;
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHold: begin
                if (if_id_wren) begin
                    if_instr_d = buf_q;
                    if_pc_d    = addr_q;
                    if_valid_d = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort overrides the FSM but leaves the IF/ID data registers untouched.
        if (!stage_reset_n) begin
            state_d    = StIdle;
            cnt_d      = '0;
            addr_d     = addr_q;
            buf_d      = buf_q;
            if_pc_d    = if_pc_q;
            if_instr_d = if_instr_q;
            if_valid_d = 1'b0;
            timeout    = 1'b0;
        end

        req_valid_d = (state_d == StReq);
        err_d       = err_q | misaligned | timeout;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            buf_q       <= '0;
            if_pc_q     <= '0;
            if_instr_q  <= '0;
            if_valid_q  <= 1'b0;
            req_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            buf_q       <= buf_d;
            if_pc_q     <= if_pc_d;
            if_instr_q  <= if_instr_d;
            if_valid_q  <= if_valid_d;
            req_valid_q <= req_valid_d;
            err_q       <= err_d;
        end
    end

    assign imem.imem_req_valid = req_valid_q;
    assign imem.imem_addr      = addr_q;
    assign pc                  = pc_cur;
    assign if_id_pc            = if_pc_q;
    assign if_id_instr         = if_instr_q;
    assign if_id_valid         = if_valid_q;
    assign fetch_err           = err_q;
    assign fetch_busy          = (state_q == StReq) || (state_q == StWait);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus randomized checks of fetch_unit against a
// transaction-level model of the PC, sticky error and IF/ID contents.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic  clk = 1'b0;
    logic  reset_n, stage_reset_n, fetch_start, pc_wren, if_id_wren, branch_taken;
    word_t branch_target;
    word_t pc, if_id_pc, if_id_instr;
    logic  if_id_valid, fetch_busy, fetch_err;
    logic  ready, resp_valid;
    word_t resp_data;

    always #5 clk = ~clk;

    fetch_unit_if imem ();
    assign imem.imem_req_ready  = ready;
    assign imem.imem_resp_valid = resp_valid;
    assign imem.imem_resp_data  = resp_data;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (255)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stage_reset_n (stage_reset_n),
        .fetch_start   (fetch_start),
        .pc_wren       (pc_wren),
        .if_id_wren    (if_id_wren),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (imem),
        .pc            (pc),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .fetch_busy    (fetch_busy),
        .fetch_err     (fetch_err)
    );

    // Reference model state
    word_t m_pc, m_ifpc, m_ifinstr;
    logic  m_err, m_ifvalid;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".err"}, {31'b0, fetch_err}, {31'b0, m_err});
        chk({tag, ".if_valid"}, {31'b0, if_id_valid}, {31'b0, m_ifvalid});
        chk({tag, ".if_pc"}, if_id_pc, m_ifpc);
        chk({tag, ".if_instr"}, if_id_instr, m_ifinstr);
    endtask

    task automatic clear_inputs();
        stage_reset_n = 1'b1;
        fetch_start   = 1'b0;
        pc_wren       = 1'b0;
        if_id_wren    = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        ready         = 1'b0;
        resp_valid    = 1'b0;
        resp_data     = '0;
    endtask

    // One clock with the currently driven inputs; PC rules applied to the model.
    task automatic cycle();
        if (pc_wren) begin
            if (branch_taken) begin
                if (branch_target[1:0] == 2'b00) m_pc = branch_target;
                else m_err = 1'b1;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        fetch_start   = 1'b1;
        pc_wren       = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0040;
        if_id_wren    = 1'b1;
        stage_reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        clear_inputs();
        m_pc = 32'h0; m_err = 1'b0; m_ifvalid = 1'b0; m_ifpc = '0; m_ifinstr = '0;
    endtask

    // Random aligned PC update traffic.
    task automatic noise();
        if ($urandom_range(0, 2) == 0) begin
            pc_wren       = 1'b1;
            branch_taken  = 1'($urandom_range(0, 1));
            branch_target = $urandom() & 32'hFFFF_FFFC;
        end
    endtask

    task automatic do_fetch(input string tag, input int rdly, input int wdly,
                            input word_t instr, input bit nz);
        word_t a;
        a = m_pc;
        fetch_start = 1'b1;
        if (nz) noise();
        cycle();
        chk({tag, ".req_busy"}, {31'b0, fetch_busy}, 32'd1);
        chk({tag, ".req_valid"}, {31'b0, imem.imem_req_valid}, 32'd1);
        chk({tag, ".req_addr"}, imem.imem_addr, a);
        for (int i = 0; i < rdly; i++) begin
            if (nz) noise();
            cycle();
            chk({tag, ".req_hold_addr"}, imem.imem_addr, a);
        end
        ready = 1'b1;
        if (nz) noise();
        cycle();
        chk({tag, ".wait_busy"}, {31'b0, fetch_busy}, 32'd1);
        chk({tag, ".wait_valid"}, {31'b0, imem.imem_req_valid}, 32'd0);
        for (int i = 0; i < wdly; i++) begin
            if (nz) begin
                noise();
                fetch_start = 1'b1;  // must be ignored while busy
            end
            cycle();
            chk({tag, ".wait_addr"}, imem.imem_addr, a);
        end
        resp_valid = 1'b1;
        resp_data  = instr;
        cycle();
        chk({tag, ".hold_busy"}, {31'b0, fetch_busy}, 32'd0);
        chk_model({tag, ".hold"});
        if_id_wren = 1'b1;
        cycle();
        m_ifpc = a; m_ifinstr = instr; m_ifvalid = 1'b1;
        chk_model({tag, ".ifid"});
    endtask

    initial begin
        clear_inputs();
        do_reset();
        chk("rst.busy", {31'b0, fetch_busy}, 32'd0);
        chk("rst.req_valid", {31'b0, imem.imem_req_valid}, 32'd0);
        chk("rst.addr", imem.imem_addr, 32'h0);
        chk_model("rst");

        // if_id_wren while idle changes nothing
        if_id_wren = 1'b1;
        cycle();
        chk_model("idle_wren");

        // Basic fetch: ready one cycle after start, response on third wait cycle
        do_fetch("basic", 0, 2, 32'h0000_0093, 1'b0);
        chk("basic.instr", if_id_instr, 32'h0000_0093);

        // Branch redirect, then fetch from the new PC
        pc_wren = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0100;
        cycle();
        chk("branch.pc", pc, 32'h0000_0100);
        do_fetch("branch", 1, 0, $urandom(), 1'b0);
        chk("branch.if_pc", if_id_pc, 32'h0000_0100);

        // Randomized fetches with concurrent PC updates
        for (int k = 0; k < 8; k++) begin
            do_fetch("rand", $urandom_range(0, 3), $urandom_range(0, 6), $urandom(), 1'b1);
        end

        // Abort during WAIT, then a late response must be dropped
        fetch_start = 1'b1; cycle();
        ready = 1'b1; cycle();
        cycle(); cycle();
        stage_reset_n = 1'b0;
        cycle();
        m_ifvalid = 1'b0;
        chk("abort.busy", {31'b0, fetch_busy}, 32'd0);
        chk("abort.req_valid", {31'b0, imem.imem_req_valid}, 32'd0);
        chk_model("abort");
        resp_valid = 1'b1; resp_data = 32'hDEAD_BEEF;
        cycle();
        chk("late.busy", {31'b0, fetch_busy}, 32'd0);
        if_id_wren = 1'b1;
        cycle();
        chk_model("late");
        do_fetch("post_abort", 0, 1, $urandom(), 1'b0);

        // PC wrap
        pc_wren = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        cycle();
        pc_wren = 1'b1;
        cycle();
        chk("wrap.pc", pc, 32'h0000_0000);
        chk_model("wrap");

        // Timeout: 255 WAIT cycles with no response
        fetch_start = 1'b1; cycle();
        ready = 1'b1; cycle();
        repeat (254) cycle();
        chk("to.pre_busy", {31'b0, fetch_busy}, 32'd1);
        chk("to.pre_err", {31'b0, fetch_err}, 32'd0);
        cycle();
        m_err = 1'b1;
        chk("to.busy", {31'b0, fetch_busy}, 32'd0);
        chk("to.req_valid", {31'b0, imem.imem_req_valid}, 32'd0);
        chk_model("to");
        stage_reset_n = 1'b0;
        cycle();
        chk("to.sticky", {31'b0, fetch_err}, 32'd1);

        // Only reset_n clears the error
        do_reset();
        chk_model("rst2");

        // Misaligned branch: PC unchanged, error set and sticky
        pc_wren = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0008;
        cycle();
        pc_wren = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0102;
        cycle();
        chk("mis.pc", pc, 32'h0000_0008);
        chk_model("mis");
        repeat (5) cycle();
        pc_wren = 1'b1;
        cycle();
        chk_model("mis.later");
        chk("mis.err", {31'b0, fetch_err}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
